// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback,
// with a mem_req/mem_ready handshake, wait timeout, sticky trap reporting and instret.
module mc_control_unit #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 instruction_or_data,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           imm_src,
    output logic [2:0]           alu_control,
    output logic [3:0]           current_state,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] CAUSE_OPCODE  = 2'b01;
    localparam logic [1:0] CAUSE_FUNCT   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  trap_q, trap_d;
    logic [1:0]            trap_cause_q, trap_cause_d;
    logic [CNT_WIDTH-1:0]  instret_q, instret_d;

    logic       timeout_hit;
    logic       mem_state;
    logic       alu_f3_ok;
    logic [2:0] alu_dec;
    logic       mem_req_c, mem_write_c, reg_write_c, ir_write_c, pc_write_c;

    // Only funct7[5] distinguishes add from sub; the other bits are don't-care here.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !mem_ready
                         && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));
    assign alu_f3_ok   = (funct3 == 3'b000) || (funct3 == 3'b010)
                         || (funct3 == 3'b110) || (funct3 == 3'b111);

    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (state_q == S_EXECR && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: begin
                        if (funct3 == 3'b010) begin
                            state_d = S_MEMADR;
                        end else begin
                            state_d      = S_TRAP;
                            trap_cause_d = CAUSE_FUNCT;
                        end
                    end
                    OP_RTYPE, OP_ITYPE: begin
                        if (alu_f3_ok) begin
                            state_d = (opcode == OP_RTYPE) ? S_EXECR : S_EXECI;
                        end else begin
                            state_d      = S_TRAP;
                            trap_cause_d = CAUSE_FUNCT;
                        end
                    end
                    OP_BRANCH: begin
                        if (funct3[2:1] == 2'b00) begin
                            state_d = S_BRANCH;
                        end else begin
                            state_d      = S_TRAP;
                            trap_cause_d = CAUSE_FUNCT;
                        end
                    end
                    OP_JAL:  state_d = S_JAL;
                    OP_LUI:  state_d = S_LUI;
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = CAUSE_OPCODE;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD, S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI: state_d = S_ALUWB;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // The wait counter restarts whenever the state changes, so each memory state gets a fresh budget.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_state && !mem_ready && (MEM_TIMEOUT != 0)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    always_comb begin
        trap_d    = trap_q | (state_d == S_TRAP);
        instret_d = instret_q;
        if (state_d == S_FETCH && (state_q == S_MEMWB || state_q == S_MEMWRITE
                                   || state_q == S_ALUWB || state_q == S_BRANCH)) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= '0;
            trap_q       <= 1'b0;
            trap_cause_q <= 2'b00;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
            instret_q    <= instret_d;
        end
    end

    always_comb begin
        mem_req_c           = 1'b0;
        mem_write_c         = 1'b0;
        reg_write_c         = 1'b0;
        ir_write_c          = 1'b0;
        pc_write_c          = 1'b0;
        instruction_or_data = 1'b0;
        result_src          = 2'b00;
        alu_src_a           = 2'b00;
        alu_src_b           = 2'b00;
        imm_src             = 3'b000;
        alu_control         = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (opcode == OP_SW) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                mem_req_c           = 1'b1;
                instruction_or_data = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_c           = 1'b1;
                mem_write_c         = 1'b1;
                instruction_or_data = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
            end
            S_ALUWB: reg_write_c = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write_c  = funct3[0] ? ~zero : zero;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                imm_src    = 3'b011;
                pc_write_c = 1'b1;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
            end
            default: ;
        endcase
    end

    // Reset gates the strobes combinationally so an abandoned access drops in the same cycle.
    assign mem_req       = mem_req_c   & ~reset;
    assign mem_write     = mem_write_c & ~reset;
    assign reg_write     = reg_write_c & ~reset;
    assign ir_write      = ir_write_c  & ~reset;
    assign pc_write      = pc_write_c  & ~reset;
    assign current_state = state_q;
    assign trap          = trap_q;
    assign trap_cause    = trap_cause_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a default-parameter instance and a
// MEM_TIMEOUT=4 / CNT_WIDTH=4 instance share stimulus, each with its own reset.
module tb_mc_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, rst1 = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;

    logic        mem_req0, mem_write0, reg_write0, ir_write0, pc_write0, iord0, trap0;
    logic [1:0]  result_src0, alu_a0, alu_b0, cause0;
    logic [2:0]  imm0, alu_ctl0;
    logic [3:0]  state0;
    logic [31:0] instret0;

    logic        mem_req1, mem_write1, reg_write1, ir_write1, pc_write1, iord1, trap1;
    logic [1:0]  result_src1, alu_a1, alu_b1, cause1;
    logic [2:0]  imm1, alu_ctl1;
    logic [3:0]  state1;
    logic [3:0]  instret1;

    int n_cmp = 0;
    int n_bad = 0;

    mc_control_unit dut (
        .clk(clk), .reset(rst0), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req0), .mem_write(mem_write0),
        .reg_write(reg_write0), .ir_write(ir_write0), .pc_write(pc_write0),
        .instruction_or_data(iord0), .result_src(result_src0), .alu_src_a(alu_a0),
        .alu_src_b(alu_b0), .imm_src(imm0), .alu_control(alu_ctl0),
        .current_state(state0), .trap(trap0), .trap_cause(cause0), .instret(instret0)
    );

    mc_control_unit #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut_p (
        .clk(clk), .reset(rst1), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req1), .mem_write(mem_write1),
        .reg_write(reg_write1), .ir_write(ir_write1), .pc_write(pc_write1),
        .instruction_or_data(iord1), .result_src(result_src1), .alu_src_a(alu_a1),
        .alu_src_b(alu_b1), .imm_src(imm1), .alu_control(alu_ctl1),
        .current_state(state1), .trap(trap1), .trap_cause(cause1), .instret(instret1)
    );

    task automatic set_instr(input logic [31:0] ins);
        opcode = ins[6:0];
        funct3 = ins[14:12];
        funct7 = ins[31:25];
    endtask

    // Release right after a rising edge, so the next falling-edge sample still sees FETCH.
    task automatic pulse_reset(input bit which);
        @(negedge clk);
        if (which) rst1 = 1'b1; else rst0 = 1'b1;
        @(posedge clk);
        #1;
        if (which) rst1 = 1'b0; else rst0 = 1'b0;
    endtask

    task automatic test_reset();
        set_instr(32'h01008193);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (state0 !== 4'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state0); end
        n_cmp++; if (mem_req0 !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got %b want 0", mem_req0); end
        n_cmp++; if (ir_write0 !== 1'b0 || pc_write0 !== 1'b0) begin n_bad++; $display("FAIL reset_ir_pc got %b%b want 00", ir_write0, pc_write0); end
        n_cmp++; if (instret0 !== 32'd0) begin n_bad++; $display("FAIL reset_instret got %0d want 0", instret0); end
        n_cmp++; if (trap0 !== 1'b0 || cause0 !== 2'b00) begin n_bad++; $display("FAIL reset_trap got %b/%b want 0/00", trap0, cause0); end
        $display("txn reset: state=%0d mem_req=%b instret=%0d", state0, mem_req0, instret0);
    endtask

    task automatic test_addi();
        logic [3:0] exp_s [5];
        exp_s = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        pulse_reset(0);
        set_instr(32'h01008193);
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (state0 !== exp_s[i]) begin n_bad++; $display("FAIL addi_state[%0d] got %0d want %0d", i, state0, exp_s[i]); end
            n_cmp++; if (reg_write0 !== (exp_s[i] == 4'd8)) begin n_bad++; $display("FAIL addi_reg_write[%0d] got %b", i, reg_write0); end
            if (i == 1) begin
                n_cmp++; if ({alu_a0, alu_b0, imm0} !== {2'b01, 2'b01, 3'b010}) begin n_bad++; $display("FAIL decode_sel got %b_%b_%b want 01_01_010", alu_a0, alu_b0, imm0); end
            end
        end
        n_cmp++; if (instret0 !== 32'd1) begin n_bad++; $display("FAIL addi_instret got %0d want 1", instret0); end
        $display("txn addi: final state=%0d instret=%0d", state0, instret0);
    endtask

    task automatic test_lw();
        logic [3:0] exp_s [9];
        exp_s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        pulse_reset(0);
        set_instr(32'h00412083);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            mem_ready = !(i >= 3 && i <= 5);
            #1;
            n_cmp++; if (state0 !== exp_s[i]) begin n_bad++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state0, exp_s[i]); end
            if (exp_s[i] == 4'd2) begin
                n_cmp++; if (imm0 !== 3'b000) begin n_bad++; $display("FAIL lw_imm got %b want 000", imm0); end
            end
            if (exp_s[i] == 4'd3) begin
                n_cmp++; if (mem_req0 !== 1'b1 || iord0 !== 1'b1 || mem_write0 !== 1'b0) begin n_bad++; $display("FAIL lw_memread got req=%b iord=%b wr=%b want 1/1/0", mem_req0, iord0, mem_write0); end
            end
            if (exp_s[i] == 4'd4) begin
                n_cmp++; if (result_src0 !== 2'b01 || reg_write0 !== 1'b1) begin n_bad++; $display("FAIL lw_memwb got src=%b rw=%b want 01/1", result_src0, reg_write0); end
            end
        end
        n_cmp++; if (instret0 !== 32'd1) begin n_bad++; $display("FAIL lw_instret got %0d want 1", instret0); end
        $display("txn lw: 8 cycles with 3 waits, instret=%0d", instret0);
    endtask

    task automatic test_sw();
        logic [3:0] exp_s [5];
        exp_s = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        pulse_reset(0);
        set_instr(32'h0020A223);
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (state0 !== exp_s[i]) begin n_bad++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state0, exp_s[i]); end
            n_cmp++; if (mem_write0 !== (exp_s[i] == 4'd5)) begin n_bad++; $display("FAIL sw_mem_write[%0d] got %b", i, mem_write0); end
            if (exp_s[i] == 4'd2) begin
                n_cmp++; if (imm0 !== 3'b001) begin n_bad++; $display("FAIL sw_imm got %b want 001", imm0); end
            end
        end
        n_cmp++; if (instret0 !== 32'd1) begin n_bad++; $display("FAIL sw_instret got %0d want 1", instret0); end
        $display("txn sw: instret=%0d", instret0);
    endtask

    task automatic test_branch(input logic z, input logic [2:0] f3, input logic exp_pw);
        logic [3:0] exp_s [4];
        exp_s = '{4'd0, 4'd1, 4'd9, 4'd0};
        pulse_reset(0);
        set_instr({7'b0, 5'd2, 5'd1, f3, 5'd8, 7'b1100011});
        mem_ready = 1'b1;
        zero = z;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (state0 !== exp_s[i]) begin n_bad++; $display("FAIL br_state[%0d] got %0d want %0d", i, state0, exp_s[i]); end
            if (exp_s[i] == 4'd9) begin
                n_cmp++; if (pc_write0 !== exp_pw) begin n_bad++; $display("FAIL br_pc_write f3=%b zero=%b got %b want %b", f3, z, pc_write0, exp_pw); end
                n_cmp++; if ({alu_a0, alu_b0, alu_ctl0} !== {2'b10, 2'b00, 3'b001}) begin n_bad++; $display("FAIL br_alu got %b_%b_%b want 10_00_001", alu_a0, alu_b0, alu_ctl0); end
            end
        end
        n_cmp++; if (instret0 !== 32'd1) begin n_bad++; $display("FAIL br_instret got %0d want 1", instret0); end
        $display("txn branch f3=%b zero=%b: expected pc_write=%b", f3, z, exp_pw);
        zero = 1'b0;
    endtask

    // Walks FETCH, DECODE, <mid>, ALUWB, FETCH and checks the mid-state selects.
    task automatic test_alu(input logic [31:0] ins, input logic [3:0] mid, input logic [2:0] exp_alu,
                            input logic [1:0] exp_a, input logic [2:0] exp_imm, input logic exp_pw);
        logic [3:0] exp_s [5];
        exp_s = '{4'd0, 4'd1, mid, 4'd8, 4'd0};
        pulse_reset(0);
        set_instr(ins);
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (state0 !== exp_s[i]) begin n_bad++; $display("FAIL flow_state[%0d] ins=%h got %0d want %0d", i, ins, state0, exp_s[i]); end
            if (i == 2) begin
                n_cmp++; if (alu_ctl0 !== exp_alu || alu_a0 !== exp_a) begin n_bad++; $display("FAIL flow_alu ins=%h got ctl=%b a=%b want ctl=%b a=%b", ins, alu_ctl0, alu_a0, exp_alu, exp_a); end
                n_cmp++; if (imm0 !== exp_imm || pc_write0 !== exp_pw) begin n_bad++; $display("FAIL flow_imm_pc ins=%h got imm=%b pcw=%b want imm=%b pcw=%b", ins, imm0, pc_write0, exp_imm, exp_pw); end
            end
        end
        n_cmp++; if (instret0 !== 32'd1) begin n_bad++; $display("FAIL flow_instret ins=%h got %0d want 1", ins, instret0); end
        $display("txn ins=%h via state %0d: alu=%b", ins, mid, exp_alu);
    endtask

    task automatic test_illegal_opcode();
        pulse_reset(0);
        set_instr(32'h0000007F);
        mem_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (state0 !== ((i == 0) ? 4'd0 : (i == 1) ? 4'd1 : 4'd12)) begin n_bad++; $display("FAIL illop_state[%0d] got %0d", i, state0); end
            if (i >= 2) begin
                n_cmp++; if (trap0 !== 1'b1 || cause0 !== 2'b01) begin n_bad++; $display("FAIL illop_trap[%0d] got %b/%b want 1/01", i, trap0, cause0); end
                n_cmp++; if ({mem_req0, mem_write0, reg_write0, ir_write0, pc_write0} !== 5'b0) begin n_bad++; $display("FAIL illop_enables[%0d] got %b want 00000", i, {mem_req0, mem_write0, reg_write0, ir_write0, pc_write0}); end
            end
        end
        pulse_reset(0);
        n_cmp++; if (state0 !== 4'd0 || trap0 !== 1'b0 || cause0 !== 2'b00) begin n_bad++; $display("FAIL illop_reset got state=%0d trap=%b cause=%b want 0/0/00", state0, trap0, cause0); end
        $display("txn illegal opcode 0x7F: held in TRAP, reset to state %0d", state0);
    endtask

    task automatic test_bad_funct(input logic [31:0] ins);
        pulse_reset(0);
        set_instr(ins);
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (state0 !== 4'd12 || cause0 !== 2'b10) begin n_bad++; $display("FAIL bad_funct ins=%h got state=%0d cause=%b want 12/10", ins, state0, cause0); end
        $display("txn bad funct ins=%h: state=%0d cause=%b", ins, state0, cause0);
    endtask

    task automatic test_timeout();
        pulse_reset(1);
        set_instr(32'h01008193);
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (state1 !== ((i < 5) ? 4'd0 : 4'd12)) begin n_bad++; $display("FAIL tmo_state[%0d] got %0d", i, state1); end
            n_cmp++; if (ir_write1 !== 1'b0) begin n_bad++; $display("FAIL tmo_ir_write[%0d] got %b want 0", i, ir_write1); end
        end
        n_cmp++; if (trap1 !== 1'b1 || cause1 !== 2'b11) begin n_bad++; $display("FAIL tmo_cause got %b/%b want 1/11", trap1, cause1); end
        $display("txn timeout: state=%0d cause=%b", state1, cause1);
        pulse_reset(1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_ready = (i == 4);
            #1;
            n_cmp++; if (state1 !== ((i < 5) ? 4'd0 : 4'd1)) begin n_bad++; $display("FAIL tmo_edge_state[%0d] got %0d", i, state1); end
            if (i < 5) begin
                n_cmp++; if (ir_write1 !== (i == 4)) begin n_bad++; $display("FAIL tmo_edge_ir[%0d] got %b", i, ir_write1); end
            end
        end
        $display("txn ready at limit: state=%0d trap=%b", state1, trap1);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_cnt;
        pulse_reset(1);
        set_instr(32'h01008193);
        mem_ready = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 17; n++) begin
            repeat (4) @(negedge clk);
            #1;
            exp_cnt = 4'(n);
            n_cmp++; if (instret1 !== exp_cnt || state1 !== 4'd0) begin n_bad++; $display("FAIL b2b[%0d] got instret=%0d state=%0d want %0d/0", n, instret1, state1, exp_cnt); end
        end
        $display("txn 17 back-to-back addi: instret=%0d", instret1);
    endtask

    task automatic test_reset_mid_write();
        pulse_reset(1);
        set_instr(32'h0020A223);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i < 3);
            #1;
        end
        n_cmp++; if (state1 !== 4'd5 || mem_write1 !== 1'b1) begin n_bad++; $display("FAIL midrst_pre got state=%0d mw=%b want 5/1", state1, mem_write1); end
        #1;
        rst1 = 1'b1;
        #1;
        n_cmp++; if (mem_write1 !== 1'b0 || mem_req1 !== 1'b0) begin n_bad++; $display("FAIL midrst_strobe got mw=%b req=%b want 0/0", mem_write1, mem_req1); end
        n_cmp++; if (state1 !== 4'd0) begin n_bad++; $display("FAIL midrst_state got %0d want 0", state1); end
        $display("txn reset during MEMWRITE: state=%0d mem_write=%b", state1, mem_write1);
        @(negedge clk);
        rst1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw();
        test_sw();
        test_branch(1'b1, 3'b000, 1'b1);
        test_branch(1'b0, 3'b000, 1'b0);
        test_branch(1'b0, 3'b001, 1'b1);
        test_branch(1'b1, 3'b001, 1'b0);
        test_alu(32'h40208033, 4'd6,  3'b001, 2'b10, 3'b000, 1'b0);
        test_alu(32'h0020E033, 4'd6,  3'b011, 2'b10, 3'b000, 1'b0);
        test_alu(32'h0020A033, 4'd6,  3'b101, 2'b10, 3'b000, 1'b0);
        test_alu(32'h0020F033, 4'd6,  3'b010, 2'b10, 3'b000, 1'b0);
        test_alu(32'h40008193, 4'd7,  3'b000, 2'b10, 3'b000, 1'b0);
        test_alu(32'h008000EF, 4'd10, 3'b000, 2'b01, 3'b011, 1'b1);
        test_alu(32'h123450B7, 4'd11, 3'b000, 2'b11, 3'b100, 1'b0);
        test_illegal_opcode();
        test_bad_funct(32'h00008003);
        test_bad_funct(32'h00204463);
        test_bad_funct(32'h00209033);
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
